// File: rtl/cpu_axi_pkg.sv
// Shared encodings and helpers for the CPU-side AXI write initiator.
// Burst and response codes, FSM states, and the 4 KB boundary check.
package cpu_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_DONE
    } state_e;

    localparam int unsigned BOUNDARY_4K = 4096;
    localparam int unsigned MAX_SIZE    = 2;

    // 16-bit span keeps (len+1)<<size exact even for the illegal sizes up to 7.
    function automatic logic crosses_4k(input logic [11:0] offset,
                                        input logic [7:0]  len,
                                        input logic [2:0]  size);
        logic [15:0] span;
        span = ({8'd0, len} + 16'd1) << size;
        return ({4'd0, offset} + span) > 16'(BOUNDARY_4K);
    endfunction

endpackage

// File: rtl/cpu_axi_sync_fifo.sv
// Single-clock FIFO holding write-data beats ahead of the W channel.
// Exposes the head entry combinationally so it can drive W payload directly.
module cpu_axi_sync_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0]   FULL_COUNT = DEPTH[PW:0];
    localparam logic [PW:0]   ONE_COUNT  = 1;
    localparam logic [PW-1:0] ONE_PTR    = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             push_en;
    logic             pop_en;

    assign o_full  = (count_q == FULL_COUNT);
    assign o_empty = (count_q == '0);
    assign o_head  = mem[rd_ptr_q];

    // A push while full is still taken when the same cycle frees a slot.
    assign pop_en  = i_pop && !o_empty;
    assign push_en = i_push && (!o_full || pop_en);

    always_ff @(posedge i_clk) begin
        if (push_en) begin
            mem[wr_ptr_q] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + ONE_PTR;
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + ONE_PTR;
            end
            unique case ({push_en, pop_en})
                2'b10:   count_q <= count_q + ONE_COUNT;
                2'b01:   count_q <= count_q - ONE_COUNT;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cpu_axi_wr_master.sv
// AXI-style write initiator: one burst command in, AW + W beats out, B collected,
// single-cycle completion pulse with the final response code.
module cpu_axi_wr_master
    import cpu_axi_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [4:0]  MST_ID     = 5'd0,
    parameter logic [3:0]  AW_CACHE   = 4'b0011,
    parameter logic [2:0]  AW_PROT    = 3'b000
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [31:0] i_cmd_addr,
    input  logic [7:0]  i_cmd_len,
    input  logic [2:0]  i_cmd_size,
    input  logic [1:0]  i_cmd_burst,

    input  logic        i_wdat_valid,
    output logic        o_wdat_ready,
    input  logic [31:0] i_wdat_data,
    input  logic [3:0]  i_wdat_strb,

    output logic        o_done_valid,
    output logic [1:0]  o_done_resp,

    output logic [4:0]  o_wid_m4_cpu2_peri,
    output logic [31:0] o_waddr_m4_cpu2_peri,
    output logic [7:0]  o_wlen_m4_cpu2_peri,
    output logic [2:0]  o_wsize_m4_cpu2_peri,
    output logic [1:0]  o_wburst_m4_cpu2_peri,
    output logic        o_wlock_m4_cpu2_peri,
    output logic [3:0]  o_wcache_m4_cpu2_peri,
    output logic [2:0]  o_wprot_m4_cpu2_peri,
    output logic        o_wvalid_m4_cpu2_peri,
    input  logic        i_wready_m4_cpu2_peri,

    output logic [31:0] o_data_m4_cpu2_peri,
    output logic [3:0]  o_strb_m4_cpu2_peri,
    output logic        o_last_m4_cpu2_peri,
    output logic        o_valid_m4_cpu2_peri,
    input  logic        i_ready_m4_cpu2_peri,

    input  logic [4:0]  i_id_m4_cpu2_peri,
    input  logic [1:0]  i_resp_m4_cpu2_peri,
    input  logic        i_valid_m4_cpu2_peri,
    output logic        o_ready_m4_cpu2_peri
);

    state_e      state_q;
    state_e      state_d;

    logic [31:0] awaddr_q;
    logic [7:0]  awlen_q;
    logic [2:0]  awsize_q;
    logic [1:0]  awburst_q;
    logic [7:0]  beat_q;
    logic [1:0]  resp_q;

    logic        cmd_hs;
    logic        cmd_bad;
    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;
    logic        last_beat;

    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [35:0] fifo_head;

    cpu_axi_sync_fifo #(
        .WIDTH (36),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (fifo_push),
        .i_push_data ({i_wdat_strb, i_wdat_data}),
        .i_pop       (fifo_pop),
        .o_head      (fifo_head),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty)
    );

    assign o_wdat_ready = !fifo_full;
    assign fifo_push    = i_wdat_valid && o_wdat_ready;
    assign fifo_pop     = w_hs;

    assign cmd_bad = (i_cmd_size > 3'(MAX_SIZE))
                  || (i_cmd_burst > BURST_INCR)
                  || ((i_cmd_burst == BURST_INCR) && crosses_4k(i_cmd_addr[11:0], i_cmd_len, i_cmd_size));

    assign cmd_hs    = i_cmd_valid && o_cmd_ready;
    assign aw_hs     = o_wvalid_m4_cpu2_peri && i_wready_m4_cpu2_peri;
    assign w_hs      = o_valid_m4_cpu2_peri && i_ready_m4_cpu2_peri;
    assign b_hs      = i_valid_m4_cpu2_peri && o_ready_m4_cpu2_peri;
    assign last_beat = (beat_q == awlen_q);

    assign o_wid_m4_cpu2_peri    = MST_ID;
    assign o_waddr_m4_cpu2_peri  = awaddr_q;
    assign o_wlen_m4_cpu2_peri   = awlen_q;
    assign o_wsize_m4_cpu2_peri  = awsize_q;
    assign o_wburst_m4_cpu2_peri = awburst_q;
    assign o_wlock_m4_cpu2_peri  = 1'b0;
    assign o_wcache_m4_cpu2_peri = AW_CACHE;
    assign o_wprot_m4_cpu2_peri  = AW_PROT;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // While reset is held, command ready stays low so every output shows its reset value.
    always_comb begin
        state_d               = state_q;
        o_cmd_ready           = 1'b0;
        o_wvalid_m4_cpu2_peri = 1'b0;
        o_valid_m4_cpu2_peri  = 1'b0;
        o_last_m4_cpu2_peri   = 1'b0;
        o_data_m4_cpu2_peri   = '0;
        o_strb_m4_cpu2_peri   = '0;
        o_ready_m4_cpu2_peri  = 1'b0;
        o_done_valid          = 1'b0;
        o_done_resp           = '0;
        unique case (state_q)
            ST_IDLE: begin
                o_cmd_ready = !i_rst;
                if (cmd_hs) begin
                    state_d = cmd_bad ? ST_DONE : ST_ADDR;
                end
            end
            ST_ADDR: begin
                o_wvalid_m4_cpu2_peri = 1'b1;
                if (aw_hs) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                o_valid_m4_cpu2_peri = !fifo_empty;
                o_last_m4_cpu2_peri  = last_beat;
                if (!fifo_empty) begin
                    o_data_m4_cpu2_peri = fifo_head[31:0];
                    o_strb_m4_cpu2_peri = fifo_head[35:32];
                end
                if (w_hs && last_beat) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                o_ready_m4_cpu2_peri = 1'b1;
                if (b_hs) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done_valid = 1'b1;
                o_done_resp  = resp_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            beat_q    <= '0;
            resp_q    <= RESP_OKAY;
        end else begin
            if ((state_q == ST_IDLE) && cmd_hs) begin
                awaddr_q  <= i_cmd_addr;
                awlen_q   <= i_cmd_len;
                awsize_q  <= i_cmd_size;
                awburst_q <= i_cmd_burst;
                beat_q    <= '0;
                resp_q    <= cmd_bad ? RESP_SLVERR : RESP_OKAY;
            end
            if (w_hs) begin
                beat_q <= beat_q + 8'd1;
            end
            if (b_hs) begin
                resp_q <= (i_id_m4_cpu2_peri == MST_ID) ? i_resp_m4_cpu2_peri : RESP_SLVERR;
            end
        end
    end

endmodule

// File: tb/tb_cpu_axi_wr_master.sv
// Directed bench for cpu_axi_wr_master: a behavioural AXI slave plus requester,
// with per-scenario tasks checking AW/W/B traffic and the completion pulse.
module tb_cpu_axi_wr_master;
    import cpu_axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_cmd_valid, o_cmd_ready;
    logic [31:0] i_cmd_addr;
    logic [7:0]  i_cmd_len;
    logic [2:0]  i_cmd_size;
    logic [1:0]  i_cmd_burst;
    logic        i_wdat_valid, o_wdat_ready;
    logic [31:0] i_wdat_data;
    logic [3:0]  i_wdat_strb;
    logic        o_done_valid;
    logic [1:0]  o_done_resp;
    logic [4:0]  o_wid;
    logic [31:0] o_waddr;
    logic [7:0]  o_wlen;
    logic [2:0]  o_wsize;
    logic [1:0]  o_wburst;
    logic        o_wlock;
    logic [3:0]  o_wcache;
    logic [2:0]  o_wprot;
    logic        o_wvalid, i_wready;
    logic [31:0] o_data;
    logic [3:0]  o_strb;
    logic        o_last, o_valid, i_ready;
    logic [4:0]  i_id;
    logic [1:0]  i_resp;
    logic        i_bvalid, o_bready;

    int tests = 0;
    int fails = 0;

    int          obs_beats, obs_last_cnt, obs_last_idx, obs_aw_cnt, obs_aw_unstable;
    int          obs_w_before_aw, obs_wvalid_bad, obs_any_axi, obs_done_cnt, obs_done_cyc;
    int          obs_timeout, obs_gaps;
    logic [31:0] obs_awaddr;
    logic [7:0]  obs_awlen;
    logic [2:0]  obs_awsize;
    logic [1:0]  obs_awburst;
    logic [1:0]  obs_done_resp;
    logic        obs_ready_after_done, obs_ready_in_done;
    logic [31:0] obs_data [16];

    always #5 clk = ~clk;

    cpu_axi_wr_master #(
        .FIFO_DEPTH (16),
        .MST_ID     (5'd0),
        .AW_CACHE   (4'b0011),
        .AW_PROT    (3'b000)
    ) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_cmd_valid           (i_cmd_valid),
        .o_cmd_ready           (o_cmd_ready),
        .i_cmd_addr            (i_cmd_addr),
        .i_cmd_len             (i_cmd_len),
        .i_cmd_size            (i_cmd_size),
        .i_cmd_burst           (i_cmd_burst),
        .i_wdat_valid          (i_wdat_valid),
        .o_wdat_ready          (o_wdat_ready),
        .i_wdat_data           (i_wdat_data),
        .i_wdat_strb           (i_wdat_strb),
        .o_done_valid          (o_done_valid),
        .o_done_resp           (o_done_resp),
        .o_wid_m4_cpu2_peri    (o_wid),
        .o_waddr_m4_cpu2_peri  (o_waddr),
        .o_wlen_m4_cpu2_peri   (o_wlen),
        .o_wsize_m4_cpu2_peri  (o_wsize),
        .o_wburst_m4_cpu2_peri (o_wburst),
        .o_wlock_m4_cpu2_peri  (o_wlock),
        .o_wcache_m4_cpu2_peri (o_wcache),
        .o_wprot_m4_cpu2_peri  (o_wprot),
        .o_wvalid_m4_cpu2_peri (o_wvalid),
        .i_wready_m4_cpu2_peri (i_wready),
        .o_data_m4_cpu2_peri   (o_data),
        .o_strb_m4_cpu2_peri   (o_strb),
        .o_last_m4_cpu2_peri   (o_last),
        .o_valid_m4_cpu2_peri  (o_valid),
        .i_ready_m4_cpu2_peri  (i_ready),
        .i_id_m4_cpu2_peri     (i_id),
        .i_resp_m4_cpu2_peri   (i_resp),
        .i_valid_m4_cpu2_peri  (i_bvalid),
        .o_ready_m4_cpu2_peri  (o_bready)
    );

    task automatic push_beats(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_wdat_valid = 1'b1;
            i_wdat_data  = base + 32'(i);
            i_wdat_strb  = 4'hF;
        end
        @(negedge clk);
        i_wdat_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int k;
        @(negedge clk);
        i_cmd_addr  = addr;
        i_cmd_len   = len;
        i_cmd_size  = size;
        i_cmd_burst = burst;
        i_cmd_valid = 1'b1;
        k = 0;
        while (!o_cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!o_cmd_ready) begin
            tests++;
            fails++;
            $display("FAIL cmd_accept: o_cmd_ready=%b after %0d cycles, required 1", o_cmd_ready, k);
        end
        @(negedge clk);
        i_cmd_valid = 1'b0;
    endtask

    // Slave + requester model; records observations from the cycle after command acceptance.
    task automatic drive_slave(input int aw_wait, input bit w_toggle,
                               input logic [4:0] b_id, input logic [1:0] b_resp,
                               input int init_occ, input logic [31:0] push_base,
                               input int n_push, input int push_period, input int abort_beats);
        int          cyc, occ, aw_wait_cnt, push_idx;
        bit          aw_seen, aw_done, last_seen, b_sent, done_seen, push_hs, pop_hs, last_hs, stop;
        logic [44:0] aw_first;
        obs_beats = 0; obs_last_cnt = 0; obs_last_idx = -1; obs_aw_cnt = 0; obs_aw_unstable = 0;
        obs_w_before_aw = 0; obs_wvalid_bad = 0; obs_any_axi = 0; obs_done_cnt = 0;
        obs_done_cyc = -1; obs_timeout = 0; obs_gaps = 0; obs_done_resp = 2'bxx;
        obs_awaddr = 'x; obs_awlen = 'x; obs_awsize = 'x; obs_awburst = 'x;
        obs_ready_after_done = 1'bx; obs_ready_in_done = 1'bx;
        for (int i = 0; i < 16; i++) obs_data[i] = 'x;
        cyc = 0; occ = init_occ; aw_wait_cnt = 0; push_idx = 0; aw_first = '0;
        aw_seen = 0; aw_done = 0; last_seen = 0; b_sent = 0; done_seen = 0; stop = 0;
        while (!stop) begin
            if (abort_beats > 0 && obs_beats >= abort_beats) break;
            push_hs = 0; pop_hs = 0; last_hs = 0;
            i_bvalid = last_seen && !b_sent;
            i_id     = b_id;
            i_resp   = b_resp;
            if (i_bvalid && o_bready) b_sent = 1;
            if (o_wvalid) begin
                obs_any_axi++;
                if (!aw_seen) begin
                    aw_first = {o_waddr, o_wlen, o_wsize, o_wburst};
                    aw_seen  = 1;
                end else if ({o_waddr, o_wlen, o_wsize, o_wburst} !== aw_first) begin
                    obs_aw_unstable++;
                end
                i_wready = (aw_wait_cnt >= aw_wait);
                aw_wait_cnt++;
                if (i_wready) begin
                    obs_aw_cnt++;
                    obs_awaddr = o_waddr; obs_awlen = o_wlen; obs_awsize = o_wsize; obs_awburst = o_wburst;
                end
            end else begin
                i_wready = 1'b0;
            end
            if (o_valid) begin
                obs_any_axi++;
                if (!aw_done) obs_w_before_aw++;
            end
            if (aw_done && !last_seen) begin
                if (o_valid !== (occ > 0)) obs_wvalid_bad++;
                if (!o_valid) obs_gaps++;
            end
            i_ready = w_toggle ? cyc[0] : 1'b1;
            if (o_valid && i_ready) begin
                pop_hs = 1;
                if (obs_beats < 16) obs_data[obs_beats] = o_data;
                if (o_last) begin
                    obs_last_cnt++;
                    obs_last_idx = obs_beats;
                    last_hs = 1;
                end
                obs_beats++;
            end
            if (push_idx < n_push && (cyc % push_period) == 0) begin
                i_wdat_valid = 1'b1;
                i_wdat_data  = push_base + 32'(push_idx);
                i_wdat_strb  = 4'hF;
                push_hs      = o_wdat_ready;
                if (push_hs) push_idx++;
            end else begin
                i_wdat_valid = 1'b0;
            end
            if (o_done_valid) begin
                obs_done_cnt++;
                obs_done_resp     = o_done_resp;
                obs_ready_in_done = o_cmd_ready;
                if (!done_seen) obs_done_cyc = cyc;
                done_seen = 1;
            end
            if (done_seen && cyc == obs_done_cyc + 1) obs_ready_after_done = o_cmd_ready;
            if (o_wvalid && i_wready) aw_done = 1;
            if (last_hs) last_seen = 1;
            occ += int'(push_hs) - int'(pop_hs);
            if (done_seen && cyc >= obs_done_cyc + 3) stop = 1;
            if (cyc >= 300) begin
                obs_timeout = 1;
                stop = 1;
            end
            cyc++;
            @(negedge clk);
        end
        i_wready = 1'b0; i_ready = 1'b0; i_bvalid = 1'b0; i_wdat_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_cmd_valid = 0; i_cmd_addr = '0; i_cmd_len = '0; i_cmd_size = '0; i_cmd_burst = '0;
        i_wdat_valid = 0; i_wdat_data = '0; i_wdat_strb = '0;
        i_wready = 0; i_ready = 0; i_id = '0; i_resp = '0; i_bvalid = 0;
        repeat (3) @(negedge clk);
        tests++; if (o_wdat_ready !== 1'b1) begin fails++; $display("FAIL rst_wdat_ready: got %b want 1", o_wdat_ready); end
        tests++; if (o_cmd_ready !== 1'b0) begin fails++; $display("FAIL rst_cmd_ready: got %b want 0", o_cmd_ready); end
        tests++; if ({o_wvalid, o_valid, o_bready, o_done_valid, o_last} !== 5'b0) begin
            fails++; $display("FAIL rst_valids: got %b want 00000", {o_wvalid, o_valid, o_bready, o_done_valid, o_last}); end
        tests++; if ({o_waddr, o_wlen, o_data, o_strb, o_done_resp} !== '0) begin
            fails++; $display("FAIL rst_payload: waddr=%h wlen=%h data=%h strb=%h resp=%h want all 0",
                              o_waddr, o_wlen, o_data, o_strb, o_done_resp); end
        tests++; if ({o_wcache, o_wprot, o_wlock, o_wid} !== {4'b0011, 3'b000, 1'b0, 5'd0}) begin
            fails++; $display("FAIL rst_aw_consts: cache=%b prot=%b lock=%b id=%h", o_wcache, o_wprot, o_wlock, o_wid); end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (o_cmd_ready !== 1'b1) begin fails++; $display("FAIL idle_cmd_ready: got %b want 1", o_cmd_ready); end
    endtask

    task automatic test_basic_incr();
        push_beats(32'hA0, 4);
        send_cmd(32'h4000_0000, 8'd3, 3'd2, BURST_INCR);
        drive_slave(0, 0, 5'd0, RESP_OKAY, 4, '0, 0, 1, 0);
        tests++; if ({obs_awaddr, obs_awlen, obs_awsize, obs_awburst} !== {32'h4000_0000, 8'd3, 3'd2, 2'd1}) begin
            fails++; $display("FAIL basic_aw: addr=%h len=%0d size=%0d burst=%0d want 40000000/3/2/1",
                              obs_awaddr, obs_awlen, obs_awsize, obs_awburst); end
        tests++; if (obs_beats !== 4) begin fails++; $display("FAIL basic_beats: got %0d want 4", obs_beats); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (obs_data[i] !== 32'hA0 + 32'(i)) begin
                fails++; $display("FAIL basic_data%0d: got %h want %h", i, obs_data[i], 32'hA0 + 32'(i)); end
        end
        tests++; if (obs_last_cnt !== 1 || obs_last_idx !== 3) begin
            fails++; $display("FAIL basic_last: count=%0d idx=%0d want 1/3", obs_last_cnt, obs_last_idx); end
        tests++; if (obs_done_cnt !== 1 || obs_done_resp !== 2'd0) begin
            fails++; $display("FAIL basic_done: pulses=%0d resp=%0d want 1/0", obs_done_cnt, obs_done_resp); end
        tests++; if (obs_done_cyc !== 6) begin fails++; $display("FAIL basic_latency: done at %0d want 6", obs_done_cyc); end
        tests++; if (obs_w_before_aw !== 0 || obs_wvalid_bad !== 0) begin
            fails++; $display("FAIL basic_wvalid: early=%0d bad=%0d want 0/0", obs_w_before_aw, obs_wvalid_bad); end
    endtask

    task automatic test_wait_states();
        push_beats(32'hB0, 4);
        send_cmd(32'h4000_0000, 8'd3, 3'd2, BURST_INCR);
        drive_slave(5, 1, 5'd0, RESP_OKAY, 4, '0, 0, 1, 0);
        tests++; if (obs_aw_unstable !== 0 || obs_aw_cnt !== 1) begin
            fails++; $display("FAIL wait_aw: unstable=%0d handshakes=%0d want 0/1", obs_aw_unstable, obs_aw_cnt); end
        tests++; if (obs_w_before_aw !== 0) begin fails++; $display("FAIL wait_w_early: got %0d want 0", obs_w_before_aw); end
        tests++; if (obs_beats !== 4 || obs_data[0] !== 32'hB0 || obs_data[1] !== 32'hB1
                     || obs_data[2] !== 32'hB2 || obs_data[3] !== 32'hB3) begin
            fails++; $display("FAIL wait_order: beats=%0d %h %h %h %h want 4 b0 b1 b2 b3",
                              obs_beats, obs_data[0], obs_data[1], obs_data[2], obs_data[3]); end
        tests++; if (obs_done_cnt !== 1 || obs_done_resp !== 2'd0 || obs_timeout !== 0) begin
            fails++; $display("FAIL wait_done: pulses=%0d resp=%0d timeout=%0d want 1/0/0",
                              obs_done_cnt, obs_done_resp, obs_timeout); end
    endtask

    task automatic test_4k_cross();
        send_cmd(32'h0000_0FF8, 8'd3, 3'd2, BURST_INCR);
        drive_slave(0, 0, 5'd0, RESP_OKAY, 0, '0, 0, 1, 0);
        tests++; if (obs_any_axi !== 0) begin fails++; $display("FAIL cross_axi: valid cycles=%0d want 0", obs_any_axi); end
        tests++; if (obs_done_cnt !== 1 || obs_done_resp !== 2'b10) begin
            fails++; $display("FAIL cross_resp: pulses=%0d resp=%b want 1/10", obs_done_cnt, obs_done_resp); end
        // Ending exactly on the boundary is legal.
        push_beats(32'h10, 4);
        send_cmd(32'h0000_0FF0, 8'd3, 3'd2, BURST_INCR);
        drive_slave(0, 0, 5'd0, RESP_OKAY, 4, '0, 0, 1, 0);
        tests++; if (obs_done_resp !== 2'b00 || obs_beats !== 4 || obs_awaddr !== 32'h0FF0) begin
            fails++; $display("FAIL edge_4k: resp=%b beats=%0d addr=%h want 00/4/00000ff0", obs_done_resp, obs_beats, obs_awaddr); end
        push_beats(32'h20, 4);
        send_cmd(32'h0000_0FF8, 8'd3, 3'd2, BURST_FIXED);
        drive_slave(0, 0, 5'd0, RESP_OKAY, 4, '0, 0, 1, 0);
        tests++; if (obs_done_resp !== 2'b00 || obs_beats !== 4 || obs_awburst !== 2'd0) begin
            fails++; $display("FAIL fixed_cross: resp=%b beats=%0d burst=%0d want 00/4/0", obs_done_resp, obs_beats, obs_awburst); end
        send_cmd(32'h0000_0000, 8'd0, 3'd3, BURST_INCR);
        drive_slave(0, 0, 5'd0, RESP_OKAY, 0, '0, 0, 1, 0);
        tests++; if (obs_done_resp !== 2'b10 || obs_any_axi !== 0) begin
            fails++; $display("FAIL bad_size: resp=%b axi=%0d want 10/0", obs_done_resp, obs_any_axi); end
        send_cmd(32'h0000_0000, 8'd0, 3'd2, 2'd2);
        drive_slave(0, 0, 5'd0, RESP_OKAY, 0, '0, 0, 1, 0);
        tests++; if (obs_done_resp !== 2'b10 || obs_any_axi !== 0) begin
            fails++; $display("FAIL bad_burst: resp=%b axi=%0d want 10/0", obs_done_resp, obs_any_axi); end
    endtask

    task automatic test_bresp();
        push_beats(32'hF0, 1);
        send_cmd(32'h0000_0100, 8'd0, 3'd2, BURST_INCR);
        drive_slave(0, 0, 5'd3, RESP_OKAY, 1, '0, 0, 1, 0);
        tests++; if (obs_done_resp !== 2'b10) begin fails++; $display("FAIL bad_id: resp=%b want 10", obs_done_resp); end
        tests++; if (obs_beats !== 1 || obs_last_cnt !== 1 || obs_last_idx !== 0 || obs_data[0] !== 32'hF0) begin
            fails++; $display("FAIL len0: beats=%0d lastcnt=%0d lastidx=%0d data=%h want 1/1/0/f0",
                              obs_beats, obs_last_cnt, obs_last_idx, obs_data[0]); end
        push_beats(32'hF1, 1);
        send_cmd(32'h0000_0200, 8'd0, 3'd2, BURST_INCR);
        drive_slave(0, 0, 5'd0, RESP_DECERR, 1, '0, 0, 1, 0);
        tests++; if (obs_done_resp !== 2'b11) begin fails++; $display("FAIL resp_pass: resp=%b want 11", obs_done_resp); end
    endtask

    task automatic test_slow_fill();
        send_cmd(32'h0000_2000, 8'd7, 3'd2, BURST_INCR);
        drive_slave(0, 0, 5'd0, RESP_OKAY, 0, 32'hC0, 8, 3, 0);
        tests++; if (obs_beats !== 8 || obs_last_idx !== 7) begin
            fails++; $display("FAIL slow_beats: beats=%0d lastidx=%0d want 8/7", obs_beats, obs_last_idx); end
        for (int i = 0; i < 8; i++) begin
            tests++; if (obs_data[i] !== 32'hC0 + 32'(i)) begin
                fails++; $display("FAIL slow_data%0d: got %h want %h", i, obs_data[i], 32'hC0 + 32'(i)); end
        end
        tests++; if (obs_wvalid_bad !== 0 || obs_gaps == 0) begin
            fails++; $display("FAIL slow_gaps: wvalid-vs-fifo errors=%0d gaps=%0d want 0/>0", obs_wvalid_bad, obs_gaps); end
        tests++; if (obs_done_cnt !== 1 || obs_done_resp !== 2'd0) begin
            fails++; $display("FAIL slow_done: pulses=%0d resp=%0d want 1/0", obs_done_cnt, obs_done_resp); end
    endtask

    task automatic test_back_to_back();
        push_beats(32'h50, 2);
        send_cmd(32'h0000_3000, 8'd0, 3'd2, BURST_INCR);
        drive_slave(0, 0, 5'd0, RESP_OKAY, 2, '0, 0, 1, 0);
        tests++; if (obs_ready_in_done !== 1'b0 || obs_ready_after_done !== 1'b1) begin
            fails++; $display("FAIL b2b_ready: in_done=%b after=%b want 0/1", obs_ready_in_done, obs_ready_after_done); end
        tests++; if (obs_data[0] !== 32'h50) begin fails++; $display("FAIL b2b_first: got %h want 50", obs_data[0]); end
        send_cmd(32'h0000_3004, 8'd0, 3'd2, BURST_INCR);
        drive_slave(0, 0, 5'd0, RESP_OKAY, 1, '0, 0, 1, 0);
        tests++; if (obs_data[0] !== 32'h51 || obs_awaddr !== 32'h3004 || obs_done_resp !== 2'd0) begin
            fails++; $display("FAIL b2b_second: data=%h addr=%h resp=%0d want 51/3004/0", obs_data[0], obs_awaddr, obs_done_resp); end
    endtask

    task automatic test_reset_mid_burst();
        int pulses;
        push_beats(32'hD0, 4);
        send_cmd(32'h0000_4000, 8'd3, 3'd2, BURST_INCR);
        drive_slave(0, 0, 5'd0, RESP_OKAY, 4, '0, 0, 1, 2);
        rst = 1'b1;
        @(negedge clk);
        tests++; if ({o_wvalid, o_valid, o_bready, o_done_valid, o_last, o_cmd_ready, o_wdat_ready} !== 7'b0000001) begin
            fails++; $display("FAIL midrst_ctrl: got %b want 0000001",
                              {o_wvalid, o_valid, o_bready, o_done_valid, o_last, o_cmd_ready, o_wdat_ready}); end
        tests++; if ({o_waddr, o_wlen, o_data} !== '0) begin
            fails++; $display("FAIL midrst_payload: waddr=%h wlen=%h data=%h want 0", o_waddr, o_wlen, o_data); end
        rst = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_done_valid) pulses++;
        end
        tests++; if (pulses !== 0) begin fails++; $display("FAIL midrst_done: pulses=%0d want 0", pulses); end
        push_beats(32'hE0, 1);
        send_cmd(32'h0000_5000, 8'd0, 3'd2, BURST_INCR);
        drive_slave(0, 0, 5'd0, RESP_OKAY, 1, '0, 0, 1, 0);
        tests++; if (obs_beats !== 1 || obs_data[0] !== 32'hE0 || obs_done_resp !== 2'd0 || obs_done_cnt !== 1) begin
            fails++; $display("FAIL midrst_recover: beats=%0d data=%h resp=%0d pulses=%0d want 1/e0/0/1",
                              obs_beats, obs_data[0], obs_done_resp, obs_done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_incr();
        test_wait_states();
        test_4k_cross();
        test_bresp();
        test_slow_fill();
        test_back_to_back();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_axi_wr_master.md
Name:
cpu_axi_wr_master

Overview:
- AXI-style write initiator: the master end of the m4_cpu2_peri write-address (AW), write-data (W) and write-response (B) channels.
- Takes one burst command plus a stream of data beats from a local requester (DMA or test engine), issues AW, streams W beats from an internal FIFO, collects B and reports completion status.
- Instantiated inside the CPU subsystem, driving the peripheral-side slave port.

Parameters:
- FIFO_DEPTH, 16, data FIFO entries; power of 2, minimum 2.
- MST_ID, 5'd0, constant driven on o_wid_m4_cpu2_peri; B responses must return this ID.
- AW_CACHE, 4'b0011, constant AWCACHE.
- AW_PROT, 3'b000, constant AWPROT.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_cmd_valid / o_cmd_ready  in/out  1/1  command handshake
- i_cmd_addr  in  32  burst start address
- i_cmd_len  in  8  beats-1
- i_cmd_size  in  3  bytes/beat = 2^size; legal values 0..2
- i_cmd_burst  in  2  0=FIXED, 1=INCR; 2 and 3 are illegal
- i_wdat_valid / o_wdat_ready  in/out  1/1  data-beat push handshake (o_wdat_ready = FIFO not full)
- i_wdat_data / i_wdat_strb  in  32/4  beat payload
- o_done_valid  out  1  one-cycle completion pulse
- o_done_resp  out  2  final response code
- o_wid/o_waddr/o_wlen/o_wsize/o_wburst_m4_cpu2_peri  out  5/32/8/3/2  AW payload
- o_wlock/o_wcache/o_wprot_m4_cpu2_peri  out  1/4/3  driven as 0/AW_CACHE/AW_PROT
- o_wvalid_m4_cpu2_peri / i_wready_m4_cpu2_peri  out/in  1/1  AW handshake
- o_data/o_strb/o_last_m4_cpu2_peri  out  32/4/1  W payload
- o_valid_m4_cpu2_peri / i_ready_m4_cpu2_peri  out/in  1/1  W handshake
- i_id/i_resp_m4_cpu2_peri  in  5/2  B payload
- i_valid_m4_cpu2_peri / o_ready_m4_cpu2_peri  in/out  1/1  B handshake

Behaviour:
- Reset: all outputs 0 except o_wdat_ready=1 (FIFO empty). FSM goes to IDLE, FIFO and beat counter clear. Reset mid-burst abandons the burst and drops FIFO contents; no o_done_valid is produced.
- FSM states: IDLE, ADDR, DATA, RESP, DONE.
- IDLE: o_cmd_ready=1. On cmd handshake, register the command.
  - Illegal command: size>2, burst>1, or INCR burst crossing a 4 KB boundary, i.e. (addr[11:0] + ((len+1)<<size)) > 4096. Go to DONE with resp 2'b10. No AXI traffic is issued.
  - Legal command: go to ADDR.
- ADDR: AW valid=1 with registered payload held stable until wready. On handshake, go to DATA in the next cycle. W valid is never asserted before AW completes.
- DATA: W valid = FIFO not empty. Payload is taken from the FIFO head; the FIFO pops on W handshake. Beat counter increments per handshake. o_last=1 when counter==len. Handshake with last set goes to RESP.
- RESP: o_ready=1. On B handshake:
  - resp = i_resp if i_id==MST_ID, else 2'b10.
  - Go to DONE.
- DONE: o_done_valid=1 for exactly one cycle, o_done_resp valid in that cycle; next state IDLE.
- FIFO accepts pushes in any state; push and pop in the same cycle are both allowed when the FIFO is full (count unchanged). Data beats may be pushed before the command is issued.
- A command with len=0 produces a single beat with last=1.
- Back-to-back commands: the next command can be accepted in the cycle after DONE, giving a minimum 1 idle cycle between bursts.
- Minimum latency with zero-wait slave and prefilled FIFO: cmd accept T, AW handshake T+1, beats T+2..T+2+len, B at T+3+len or later, done pulse one cycle after the B handshake.

Decomposition:
- Package cpu_axi_pkg: burst encodings (FIXED/INCR), response encodings (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), FSM state enum, 4 KB boundary constant.
- Sub-module cpu_axi_sync_fifo: parameterised width (36) and depth; outputs full, empty, head data.

Test Plan:
- addr 0x4000_0000, len=3, INCR, size=2, data 0xA0..0xA3 prefilled, zero-wait slave, B resp=0 id=0 -> waddr=0x40000000, wlen=3, 4 beats, last only on 0xA3, done_resp=0.
- Same command with wready held low 5 cycles, and i_ready toggling every other cycle -> AW payload stable while waiting, no W before AW, beat order preserved, done pulse width 1.
- addr 0x0000_0FF8, len=3, size=2 -> 4 KB cross detected: no AW/W valid ever asserted, done_resp=2'b10.
- B returns id=5'd3 with resp=0 -> done_resp=2'b10.
- FIFO empty at DATA entry; push one beat every 3 cycles with len=7 -> W valid gaps follow FIFO empty, exactly 8 beats sent.
- Assert i_rst in DATA after 2 of 4 beats -> all outputs return to reset values next cycle, no done pulse; a new command afterwards completes normally.
